// File: rtl/pc_gen_ras.sv
// pc_gen_ras: program-counter generator for the fetch stage.
//
// Adds a return-address stack (RAS), exception entry/return with a saved EPC,
// and a RUN/HALTED state machine.
//
// Ports:
//   clk, rst_n     rising-edge clock; asynchronous active-low reset
//   stall          hold the PC in RUN (hazard)
//   redirect       taken branch/jump; next PC = redirect_addr
//   redirect_addr  branch/jump target; also the fallback target for ret on an empty RAS
//   call           qualifies redirect as a call; pushes ret_addr_in
//   ret_addr_in    return address pushed on call
//   ret            return; next PC = RAS top, then pop
//   exc            exception; next PC = EXC_VEC, epc <= pc_out
//   rfe            return from exception; next PC = epc
//   halt, resume   enter / leave HALTED
//   pc_out         current PC (registered)
//   pc_valid       1 in RUN, 0 in HALTED
//   epc            saved exception PC
//   ras_empty      RAS count is 0
//   ras_full       RAS count is RAS_DEPTH
//   ras_underflow  one-cycle pulse when ret is taken on an empty RAS
module pc_gen_ras #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INC       = 1,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]  EXC_VEC   = 2,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              call,
    input  logic [ADDR_W-1:0] ret_addr_in,
    input  logic              ret,
    input  logic              exc,
    input  logic              rfe,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] epc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_underflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pcState_t;

    pcState_t           state;
    logic [ADDR_W-1:0]  pcReg;
    logic [ADDR_W-1:0]  epcReg;
    logic               underflowReg;
    logic [ADDR_W-1:0]  rasMem [RAS_DEPTH];
    logic [PTR_W-1:0]   topPtr;
    logic [CNT_W-1:0]   rasCount;

    logic inRun;
    logic active;
    logic doPop;
    logic doPush;
    logic doUnder;

    // Decode of the RUN-state priority chain into RAS actions. "active" means
    // nothing above ret in the chain (exc, rfe, stall) claimed this cycle.
    always_comb begin
        inRun   = (state == RUN);
        active  = inRun && !exc && !rfe && !stall;
        doPop   = active && ret && (rasCount != '0);
        doUnder = active && ret && (rasCount == '0);
        doPush  = active && !ret && redirect && call;
    end

    // PC, EPC and state machine. exc is honoured in both states; everything
    // else only in RUN, except resume, which only matters in HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            pcReg        <= RESET_VEC;
            epcReg       <= '0;
            underflowReg <= 1'b0;
        end else begin
            underflowReg <= doUnder;
            if (exc) begin
                pcReg  <= EXC_VEC;
                epcReg <= pcReg;
                state  <= RUN;
            end else if (!inRun) begin
                if (resume) begin
                    state <= RUN;
                end
            end else if (rfe) begin
                pcReg <= epcReg;
            end else if (stall) begin
                pcReg <= pcReg;
            end else if (ret) begin
                pcReg <= (rasCount != '0) ? rasMem[topPtr] : redirect_addr;
            end else if (redirect) begin
                pcReg <= redirect_addr;
            end else if (halt) begin
                state <= HALTED;
            end else begin
                pcReg <= pcReg + ADDR_W'(INC);
            end
        end
    end

    // RAS bookkeeping. The buffer is circular, so a push when full lands on
    // the oldest slot and the count saturates at RAS_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            topPtr   <= '0;
            rasCount <= '0;
        end else if (doPop) begin
            topPtr   <= topPtr - PTR_ONE;
            rasCount <= rasCount - CNT_ONE;
        end else if (doPush) begin
            topPtr   <= topPtr + PTR_ONE;
            if (rasCount != CNT_MAX) begin
                rasCount <= rasCount + CNT_ONE;
            end
        end
    end

    // RAS storage needs no reset; entries are only read while the count says
    // they are valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            rasMem[topPtr + PTR_ONE] <= ret_addr_in;
        end
    end

    assign pc_out        = pcReg;
    assign pc_valid      = (state == RUN);
    assign epc           = epcReg;
    assign ras_empty     = (rasCount == '0);
    assign ras_full      = (rasCount == CNT_MAX);
    assign ras_underflow = underflowReg;

endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: directed self-checking bench for pc_gen_ras with default
// parameters (ADDR_W=16, INC=1, RESET_VEC=0, EXC_VEC=2, RAS_DEPTH=4).
module tb_pc_gen_ras;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        call;
    logic [15:0] ret_addr_in;
    logic        ret;
    logic        exc;
    logic        rfe;
    logic        halt;
    logic        resume;
    logic [15:0] pc_out;
    logic        pc_valid;
    logic [15:0] epc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;

    int testCount = 0;
    int failCount = 0;

    pc_gen_ras dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .call          (call),
        .ret_addr_in   (ret_addr_in),
        .ret           (ret),
        .exc           (exc),
        .rfe           (rfe),
        .halt          (halt),
        .resume        (resume),
        .pc_out        (pc_out),
        .pc_valid      (pc_valid),
        .epc           (epc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
        call = 1'b0; ret_addr_in = '0; ret = 1'b0; exc = 1'b0; rfe = 1'b0;
        halt = 1'b0; resume = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_pc", 32'(pc_out), 32'h0);
        checkOutput("rst_valid", 32'(pc_valid), 32'h1);
        checkOutput("rst_epc", 32'(epc), 32'h0);
        checkOutput("rst_empty", 32'(ras_empty), 32'h1);
        checkOutput("rst_full", 32'(ras_full), 32'h0);
        checkOutput("rst_underflow", 32'(ras_underflow), 32'h0);
        rst_n = 1'b1;

        // Sequential count 1..5
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            checkOutput("seq_pc", 32'(pc_out), 32'(i));
        end
        checkOutput("seq_valid", 32'(pc_valid), 32'h1);

        // Asynchronous reset mid-count, checked before the next edge
        #2 rst_n = 1'b0;
        #1 checkOutput("async_rst_pc", 32'(pc_out), 32'h0);
        #1 rst_n = 1'b1;

        // Wrap 0xFFFE -> 0xFFFF -> 0x0000
        redirect = 1'b1; redirect_addr = 16'hFFFE;
        applyStimulus();
        checkOutput("wrap_load", 32'(pc_out), 32'hFFFE);
        redirect = 1'b0;
        applyStimulus();
        checkOutput("wrap_ffff", 32'(pc_out), 32'hFFFF);
        applyStimulus();
        checkOutput("wrap_zero", 32'(pc_out), 32'h0000);

        // Stall beats redirect; held redirect then takes effect
        redirect = 1'b1; redirect_addr = 16'h0010;
        applyStimulus();
        checkOutput("stall_setup", 32'(pc_out), 32'h10);
        stall = 1'b1; redirect_addr = 16'h0040;
        applyStimulus();
        checkOutput("stall_hold", 32'(pc_out), 32'h10);
        stall = 1'b0;
        applyStimulus();
        checkOutput("stall_release", 32'(pc_out), 32'h40);
        redirect = 1'b0;
        applyStimulus();
        checkOutput("stall_inc", 32'(pc_out), 32'h41);

        // RAS: five calls (fifth overwrites oldest), four rets, underflow
        redirect = 1'b1; call = 1'b1; redirect_addr = 16'h0100;
        ret_addr_in = 16'h0011;
        applyStimulus();
        checkOutput("call1_pc", 32'(pc_out), 32'h100);
        checkOutput("call1_empty", 32'(ras_empty), 32'h0);
        ret_addr_in = 16'h0022; applyStimulus();
        ret_addr_in = 16'h0033; applyStimulus();
        checkOutput("call3_full", 32'(ras_full), 32'h0);
        ret_addr_in = 16'h0044; applyStimulus();
        checkOutput("call4_full", 32'(ras_full), 32'h1);
        ret_addr_in = 16'h0055; applyStimulus();
        checkOutput("call5_full", 32'(ras_full), 32'h1);
        redirect = 1'b0; call = 1'b0; ret = 1'b1;
        applyStimulus();
        checkOutput("ret1_pc", 32'(pc_out), 32'h55);
        checkOutput("ret1_full", 32'(ras_full), 32'h0);
        applyStimulus();
        checkOutput("ret2_pc", 32'(pc_out), 32'h44);
        applyStimulus();
        checkOutput("ret3_pc", 32'(pc_out), 32'h33);
        applyStimulus();
        checkOutput("ret4_pc", 32'(pc_out), 32'h22);
        checkOutput("ret4_empty", 32'(ras_empty), 32'h1);
        checkOutput("ret4_underflow", 32'(ras_underflow), 32'h0);
        redirect_addr = 16'h0099;
        applyStimulus();
        checkOutput("ret5_pc", 32'(pc_out), 32'h99);
        checkOutput("ret5_underflow", 32'(ras_underflow), 32'h1);
        checkOutput("ret5_empty", 32'(ras_empty), 32'h1);
        ret = 1'b0;
        applyStimulus();
        checkOutput("post_ret_pc", 32'(pc_out), 32'h9A);
        checkOutput("underflow_pulse", 32'(ras_underflow), 32'h0);

        // Exception entry and return
        redirect = 1'b1; redirect_addr = 16'h0030;
        applyStimulus();
        redirect = 1'b0; exc = 1'b1;
        applyStimulus();
        checkOutput("exc_pc", 32'(pc_out), 32'h2);
        checkOutput("exc_epc", 32'(epc), 32'h30);
        exc = 1'b0;
        applyStimulus();
        checkOutput("exc_inc3", 32'(pc_out), 32'h3);
        applyStimulus();
        checkOutput("exc_inc4", 32'(pc_out), 32'h4);
        rfe = 1'b1;
        applyStimulus();
        checkOutput("rfe_pc", 32'(pc_out), 32'h30);
        checkOutput("rfe_epc", 32'(epc), 32'h30);
        rfe = 1'b0; redirect = 1'b1; redirect_addr = 16'h0004;
        applyStimulus();
        redirect = 1'b0; exc = 1'b1; rfe = 1'b1;
        applyStimulus();
        checkOutput("excrfe_pc", 32'(pc_out), 32'h2);
        checkOutput("excrfe_epc", 32'(epc), 32'h4);
        exc = 1'b0; rfe = 1'b0;

        // Halt, ignored redirect, resume
        redirect = 1'b1; redirect_addr = 16'h0008;
        applyStimulus();
        redirect = 1'b0; halt = 1'b1;
        applyStimulus();
        checkOutput("halt_pc", 32'(pc_out), 32'h8);
        checkOutput("halt_valid", 32'(pc_valid), 32'h0);
        halt = 1'b0; redirect = 1'b1; redirect_addr = 16'h0077;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("halted_pc", 32'(pc_out), 32'h8);
            checkOutput("halted_valid", 32'(pc_valid), 32'h0);
        end
        redirect = 1'b0; resume = 1'b1;
        applyStimulus();
        checkOutput("resume_valid", 32'(pc_valid), 32'h1);
        checkOutput("resume_pc", 32'(pc_out), 32'h8);
        resume = 1'b0;
        applyStimulus();
        checkOutput("resume_inc", 32'(pc_out), 32'h9);

        // Halt again, exception leaves HALTED
        redirect = 1'b1; redirect_addr = 16'h0008;
        applyStimulus();
        redirect = 1'b0; halt = 1'b1;
        applyStimulus();
        checkOutput("halt2_valid", 32'(pc_valid), 32'h0);
        halt = 1'b0; exc = 1'b1;
        applyStimulus();
        checkOutput("halt_exc_pc", 32'(pc_out), 32'h2);
        checkOutput("halt_exc_epc", 32'(epc), 32'h8);
        checkOutput("halt_exc_valid", 32'(pc_valid), 32'h1);
        exc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
